enocoro_stream_ctrl: RTL

Sequencer and host adapter for the 4-bit Enocoro-128v2 keystream core.
- On a start request it latches a 128-bit key and 64-bit IV, pulses the core's reset, and feeds the 48 seed nibbles in the core's load window.
- It waits for initialisation to finish, then packs the core's free-running keystream nibble pairs into bytes in a small FIFO.
- It XORs those bytes with a byte-wide valid/ready data stream.
- It sits between the host bus/DMA and the cipher core instance.

---
 rtl/enocoro_stream_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/enocoro_stream_ctrl.sv
// Enocoro-128v2 sequencer: rekeys the 4-bit core, packs keystream nibbles into a byte FIFO, XORs a byte stream.
// Optional ENOCORO_STREAM_CTRL_BYTECNT_EN adds a 32-bit output handshake counter (byte_count).
module enocoro_stream_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int WDOG_CYCLES  = 1023,
  parameter int LOAD_NIBBLES = 48
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [63:0]  iv,
  output logic         busy,
  output logic         ks_ready,
  output logic         error,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [7:0]   m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         core_rst_n,
  output logic [3:0]   core_din,
  input  logic [3:0]   core_dout,
  input  logic         core_valid
`ifdef ENOCORO_STREAM_CTRL_BYTECNT_EN
  ,
  output logic [31:0]  byte_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam int LW = $clog2(LOAD_NIBBLES);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_LOAD, S_INIT, S_RUN, S_ERR} state_t;

  state_t          state, state_n;
  logic [191:0]    seed_q;
  logic [LW-1:0]   cnt;
  logic [WW-1:0]   wdog;
  logic            pair_vld;
  logic [3:0]      pair_hi;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            start_acc, push, pop, full, do_push, overflow, wdog_expire;

  assign start_acc   = start && (state == S_IDLE || state == S_RUN || state == S_ERR);
  assign full        = (count == CW'(FIFO_DEPTH));
  assign s_ready     = (state == S_RUN) && (count != '0) && (!m_valid || m_ready);
  assign pop         = s_valid && s_ready;
  assign push        = (state == S_RUN) && core_valid && pair_vld;
  assign do_push     = push && (!full || pop);
  assign overflow    = push && full && !pop;
  assign wdog_expire = (state == S_INIT) && !core_valid && (wdog == WW'(WDOG_CYCLES - 1));
  assign busy        = (state == S_RST) || (state == S_LOAD) || (state == S_INIT);
  assign ks_ready    = (state == S_RUN);
  assign core_din    = (state == S_LOAD) ? seed_q[{cnt, 2'b00} +: 4] : 4'h0;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start_acc) state_n = S_RST;
      S_RST:  state_n = S_LOAD;
      S_LOAD: if (cnt == LW'(LOAD_NIBBLES - 1)) state_n = S_INIT;
      S_INIT: begin
        if (core_valid)       state_n = S_RUN;
        else if (wdog_expire) state_n = S_ERR;
      end
      S_RUN: begin
        if (start_acc)     state_n = S_RST;
        else if (overflow) state_n = S_ERR;
      end
      S_ERR:  if (start_acc) state_n = S_RST;
      default: state_n = S_IDLE;
    endcase
  end

  // core_rst_n is registered from next state so the core sees exactly the RST cycle low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      core_rst_n <= 1'b0;
      seed_q     <= '0;
      cnt        <= '0;
      wdog       <= '0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      core_rst_n <= (state_n != S_RST);
      if (start_acc) seed_q <= {iv, key};
      if (state == S_RST)       cnt <= '0;
      else if (state == S_LOAD) cnt <= cnt + LW'(1);
      if (state == S_INIT) wdog <= wdog + WW'(1);
      else                 wdog <= '0;
      if (overflow || wdog_expire) error <= 1'b1;
      else if (start_acc)          error <= 1'b0;
    end
  end

  // A lone valid cycle leaves pair_vld set for one cycle only; the half byte is then dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pair_vld <= 1'b0;
      pair_hi  <= 4'h0;
    end else if ((state == S_INIT || state == S_RUN) && core_valid) begin
      pair_vld <= !pair_vld;
      if (!pair_vld) pair_hi <= core_dout;
    end else begin
      pair_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {pair_hi, core_dout};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (state == S_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
    end else if (start_acc || state == S_RST) begin
      m_valid <= 1'b0;
    end else if (pop) begin
      m_data  <= s_data ^ mem[rd_ptr];
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef ENOCORO_STREAM_CTRL_BYTECNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                byte_count <= '0;
    else if (state == S_RST)     byte_count <= '0;
    else if (m_valid && m_ready) byte_count <= byte_count + 32'd1;
  end
`endif

endmodule
